// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared definitions for the parametrised synchronous FIFO.
//   - fwft_mode_e : output mode selector values for the FWFT parameter
//   - ptr_w()     : pointer width for a given depth
//   - cnt_w()     : occupancy counter width (must represent 0..DEPTH)
//   - is_pow2()   : depth legality helper
package fifo_sync_pkg;

    typedef enum int unsigned {
        FWFT_STD       = 0,  // registered read data, 1-cycle latency
        FWFT_SHOWAHEAD = 1   // head word presented combinationally
    } fwft_mode_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned depth);
        return (depth != 0) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// fifo_sync_if: data/handshake/status bundle between a FIFO and its user.
//   master : user side   - drives flush, din, write, read; observes status
//   slave  : FIFO side   - drives dout, empty, full, almost_*, count, overflow, underflow
interface fifo_sync_if
    import fifo_sync_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic             flush;
    logic [WIDTH-1:0] din;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, din, write, read,
        input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  flush, din, write, read,
        output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_mem.sv
// fifo_mem: DEPTH x WIDTH storage array for fifo_sync.
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - read data
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO.
//   clk    - sole clock
//   clr_n  - synchronous active-low reset
//   bus    - fifo_sync_if.slave: flush/din/write/read in;
//            dout, empty, full, almost_empty, almost_full, count, overflow, underflow out
// Priority each edge: reset > flush > read/write. All status flags are registered
// and computed from the next-state count, so none has a combinational input path.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = 0
) (
    input logic        clk,
    input logic        clr_n,
    fifo_sync_if.slave bus
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of 2 and >= 2");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("fifo_sync: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_sync: WIDTH must be >= 1");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
    logic             rd_ok, wr_ok;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    always_comb begin
        rd_ok    = bus.read & ~empty_q;
        // A write while full lands only because a same-edge read frees a slot.
        wr_ok    = bus.write & (~full_q | rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage must not be disturbed by a request on a reset or flush edge.
    assign mem_we = wr_ok & clr_n & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!clr_n || bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            ae_q     <= (count_d <= CW'(AE_LEVEL));
            af_q     <= (count_d >= CW'(AF_LEVEL));
            ovf_q    <= bus.write & ~wr_ok;
            udf_q    <= bus.read & ~rd_ok;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.din),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    if (FWFT == FWFT_SHOWAHEAD) begin : g_fwft
        assign bus.dout = mem_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        // Flush keeps the last delivered word; only reset clears it.
        always_ff @(posedge clk) begin
            if (!clr_n) begin
                dout_q <= '0;
            end else if (!bus.flush && rd_ok) begin
                dout_q <= mem_rdata;
            end
        end
        assign bus.dout = dout_q;
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
